// File: rtl/pipe_lr_if.sv
// pipe_lr_if: valid/ready/data handshake bundle for pipe_lr.
// The master drives vld/data and observes rdy; the slave does the reverse.
interface pipe_lr_if #(
   parameter int unsigned DW = 32
);
   logic          vld;
   logic          rdy;
   logic [DW-1:0] data;

   modport master (
      output vld,
      output data,
      input  rdy
   );

   modport slave (
      input  vld,
      input  data,
      output rdy
   );
endinterface

// File: rtl/pipe_lr.sv
// pipe_lr: DEPTH-stage valid/ready pipeline register with flush and reset value.
// Empty stages always accept, so stalls squeeze out bubbles instead of
// stalling the whole pipe. Stage DEPTH-1 drives the outputs. DEPTH: 1..8.
module pipe_lr #(
   parameter int unsigned   DW      = 32,
   parameter int unsigned   DEPTH   = 2,
   parameter logic [DW-1:0] RST_VAL = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_flush,
   pipe_lr_if.slave                     i_in,
   pipe_lr_if.master                    o_out,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] r_v;
   logic [DW-1:0]    r_d [DEPTH];
   logic [CW-1:0]    r_cnt;

   logic [DEPTH-1:0] w_rdy;
   logic [DEPTH-1:0] w_src_v;
   logic [DW-1:0]    w_src_d [DEPTH];
   logic [DEPTH-1:0] w_ld;
   logic [DEPTH-1:0] w_v_nxt;
   logic [CW-1:0]    w_cnt_nxt;

   // Ready chain: a stage can take a beat when empty or when its occupant moves on.
   always_comb begin
      w_rdy = '0;
      w_rdy[DEPTH-1] = ~r_v[DEPTH-1] | o_out.rdy;
      for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
         w_rdy[i] = ~r_v[i] | w_rdy[i+1];
      end
   end

   // Source of each stage: upstream port for stage 0, the previous stage otherwise.
   always_comb begin
      w_src_v    = '0;
      w_src_v[0] = i_in.vld;
      w_src_d[0] = i_in.data;
      for (int i = 1; i < int'(DEPTH); i++) begin
         w_src_v[i] = r_v[i-1];
         w_src_d[i] = r_d[i-1];
      end
   end

   // Next valid bits, data load enables and registered occupancy.
   always_comb begin
      w_v_nxt   = r_v;
      w_ld      = '0;
      w_cnt_nxt = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (w_rdy[i] && !i_flush) begin
            w_v_nxt[i] = w_src_v[i];
            // Data only moves with a valid beat; bubbles leave the register untouched.
            w_ld[i]    = w_src_v[i];
         end
      end
      if (i_flush) begin
         w_v_nxt = '0;
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
         w_cnt_nxt = w_cnt_nxt + CW'(w_v_nxt[i]);
      end
   end

   // Stage state; reset wins over flush and any handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_v   <= '0;
         r_cnt <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_d[i] <= RST_VAL;
         end
      end else begin
         r_v   <= w_v_nxt;
         r_cnt <= w_cnt_nxt;
         for (int i = 0; i < int'(DEPTH); i++) begin
            if (w_ld[i]) begin
               r_d[i] <= w_src_d[i];
            end
         end
      end
   end

   // Flush blocks new input; an output transfer in the flush cycle still completes.
   assign i_in.rdy   = w_rdy[0] & ~i_flush;
   assign o_out.vld  = r_v[DEPTH-1];
   assign o_out.data = r_d[DEPTH-1];
   assign o_count    = r_cnt;

endmodule

// File: tb/tb_pipe_lr.sv
// tb_pipe_lr: drives pipe_lr at DEPTH=3 and DEPTH=1 with directed and random
// traffic and compares every cycle against a queue-of-beats reference model.
module tb_pipe_lr;

   localparam logic [31:0] RV3 = 32'hDEAD_BEEF;
   localparam logic [31:0] RV1 = 32'h0BAD_F00D;

   logic       clk = 1'b0;
   logic       rst3, rst1, flush3, flush1;
   logic [1:0] cnt3;
   logic [0:0] cnt1;

   always #5 clk = ~clk;

   pipe_lr_if #(.DW(32)) in3 ();
   pipe_lr_if #(.DW(32)) out3 ();
   pipe_lr_if #(.DW(32)) in1 ();
   pipe_lr_if #(.DW(32)) out1 ();

   pipe_lr #(.DW(32), .DEPTH(3), .RST_VAL(RV3)) u_dut3 (
      .clk     (clk),
      .rst     (rst3),
      .i_flush (flush3),
      .i_in    (in3),
      .o_out   (out3),
      .o_count (cnt3)
   );

   pipe_lr #(.DW(32), .DEPTH(1), .RST_VAL(RV1)) u_dut1 (
      .clk     (clk),
      .rst     (rst1),
      .i_flush (flush1),
      .i_in    (in1),
      .o_out   (out1),
      .o_count (cnt1)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: in-flight beats, oldest first, each with its stage position.
   int          sel;
   int          md;
   logic [31:0] mrst;
   logic [31:0] mlast;
   logic [31:0] mq_d[$];
   int          mq_p[$];
   bit          armed;

   logic        obs_vld, obs_rdy;
   logic [31:0] obs_data, obs_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s (DEPTH=%0d, t=%0t): got %h expected %h", tag, md, $time, got, exp);
      end
   endtask

   task automatic select_dut(input int s);
      sel   = s;
      md    = (s == 0) ? 3 : 1;
      mrst  = (s == 0) ? RV3 : RV1;
      mlast = mrst;
      armed = 1'b0;
      mq_d.delete();
      mq_p.delete();
   endtask

   // One clock cycle: drive at negedge, check just after, advance model for the posedge.
   task automatic cycle(input bit r, input bit f, input bit iv, input logic [31:0] id,
                        input bit ordy);
      int np[$];
      int lim, p, first;
      bit pop, exp_vld, exp_rdy;
      rst3     = (sel == 0) ? r : 1'b1;
      flush3   = (sel == 0) ? f : 1'b0;
      in3.vld  = (sel == 0) ? iv : 1'b0;
      in3.data = id;
      out3.rdy = (sel == 0) ? ordy : 1'b0;
      rst1     = (sel == 1) ? r : 1'b1;
      flush1   = (sel == 1) ? f : 1'b0;
      in1.vld  = (sel == 1) ? iv : 1'b0;
      in1.data = id;
      out1.rdy = (sel == 1) ? ordy : 1'b0;
      #1;
      obs_vld  = (sel == 1) ? out1.vld  : out3.vld;
      obs_rdy  = (sel == 1) ? in1.rdy   : in3.rdy;
      obs_data = (sel == 1) ? out1.data : out3.data;
      obs_cnt  = (sel == 1) ? 32'(cnt1) : 32'(cnt3);

      exp_vld = (mq_p.size() > 0) && (mq_p[0] == md - 1);
      pop     = exp_vld && ordy;
      first   = pop ? 1 : 0;
      // Each beat advances one stage unless it would collide with the beat ahead.
      lim = md;
      for (int j = first; j < mq_p.size(); j++) begin
         p = mq_p[j] + 1;
         if (p > lim - 1) p = lim - 1;
         np.push_back(p);
         lim = p;
      end
      exp_rdy = !f && ((np.size() == 0) || (np[np.size()-1] >= 1));

      if (armed) begin
         check("out_vld", 32'(obs_vld), 32'(exp_vld));
         check("out_data", obs_data, mlast);
         check("count", obs_cnt, 32'(mq_p.size()));
         check("in_rdy", 32'(obs_rdy), 32'(exp_rdy));
      end

      if (r) begin
         mq_d.delete();
         mq_p.delete();
         mlast = mrst;
         armed = 1'b1;
      end else begin
         if (pop) begin
            void'(mq_d.pop_front());
            void'(mq_p.pop_front());
         end
         if (f) begin
            mq_d.delete();
            mq_p.delete();
         end else begin
            for (int j = 0; j < mq_p.size(); j++) begin
               if (np[j] == md - 1 && mq_p[j] != md - 1) mlast = mq_d[j];
               mq_p[j] = np[j];
            end
            if (iv && exp_rdy) begin
               mq_d.push_back(id);
               mq_p.push_back(0);
               if (md == 1) mlast = id;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n, input bit ordy);
      for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, $urandom, ordy);
   endtask

   task automatic random_phase(input int n);
      for (int k = 0; k < n; k++) begin
         cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0),
               1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 9) < 6));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst3 = 1'b1; rst1 = 1'b1; flush3 = 1'b0; flush1 = 1'b0;
      in3.vld = 1'b0; in3.data = '0; out3.rdy = 1'b0;
      in1.vld = 1'b0; in1.data = '0; out1.rdy = 1'b0;
      @(negedge clk);

      // ---------------- DEPTH = 3 ----------------
      select_dut(0);
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1);
      check("rst_vld", 32'(obs_vld), 32'd0);
      check("rst_data", obs_data, 32'hDEAD_BEEF);
      check("rst_cnt", obs_cnt, 32'd0);
      check("rst_rdy", 32'(obs_rdy), 32'd1);

      // Streaming: 1 appears three edges after its accept.
      cycle(0, 0, 1, 1, 1);
      cycle(0, 0, 1, 2, 1);
      cycle(0, 0, 1, 3, 1);
      cycle(0, 0, 1, 4, 1);
      check("stream_lat_vld", 32'(obs_vld), 32'd1);
      check("stream_lat_data", obs_data, 32'd1);
      cycle(0, 0, 1, 5, 1);
      check("stream_data2", obs_data, 32'd2);
      check("stream_cnt", obs_cnt, 32'd3);
      idle(4, 1);

      // Backpressure fill then release.
      cycle(0, 0, 1, 32'hA, 0);
      cycle(0, 0, 1, 32'hB, 0);
      cycle(0, 0, 1, 32'hC, 0);
      cycle(0, 0, 1, 32'hD, 0);
      check("bp_rdy", 32'(obs_rdy), 32'd0);
      check("bp_cnt", obs_cnt, 32'd3);
      check("bp_data", obs_data, 32'hA);
      cycle(0, 0, 1, 32'hD, 0);
      check("bp_hold", obs_data, 32'hA);
      cycle(0, 0, 1, 32'hD, 1);
      check("bp_rel_rdy", 32'(obs_rdy), 32'd1);
      cycle(0, 0, 0, 0, 1);
      check("bp_out_b", obs_data, 32'hB);
      cycle(0, 0, 0, 0, 1);
      check("bp_out_c", obs_data, 32'hC);
      cycle(0, 0, 0, 0, 1);
      check("bp_out_d", obs_data, 32'hD);
      idle(2, 1);

      // Bubble collapse under stall.
      cycle(0, 0, 1, 32'h1, 0);
      idle(2, 0);
      cycle(0, 0, 1, 32'h2, 0);
      cycle(0, 0, 0, 0, 0);
      check("bub_cnt", obs_cnt, 32'd2);
      check("bub_data", obs_data, 32'h1);
      check("bub_rdy", 32'(obs_rdy), 32'd1);
      idle(4, 1);

      // Flush with a full pipe.
      cycle(0, 0, 1, 32'hA, 0);
      cycle(0, 0, 1, 32'hB, 0);
      cycle(0, 0, 1, 32'hC, 0);
      cycle(0, 1, 1, 32'hE, 1);
      check("fl_vld", 32'(obs_vld), 32'd1);
      check("fl_data", obs_data, 32'hA);
      check("fl_rdy", 32'(obs_rdy), 32'd0);
      cycle(0, 0, 0, 0, 1);
      check("fl_after_vld", 32'(obs_vld), 32'd0);
      check("fl_after_cnt", obs_cnt, 32'd0);
      check("fl_after_rdy", 32'(obs_rdy), 32'd1);
      idle(3, 1);

      // Reset mid-stream.
      cycle(0, 0, 1, 32'h11, 0);
      cycle(0, 0, 1, 32'h22, 0);
      cycle(1, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 1);
      check("mrst_cnt", obs_cnt, 32'd0);
      check("mrst_data", obs_data, 32'hDEAD_BEEF);

      random_phase(400);

      // ---------------- DEPTH = 1 ----------------
      select_dut(1);
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1);
      check("d1_rst_data", obs_data, 32'h0BAD_F00D);
      check("d1_rst_cnt", obs_cnt, 32'd0);

      cycle(0, 0, 1, 1, 1);
      cycle(0, 0, 1, 2, 1);
      check("d1_lat_vld", 32'(obs_vld), 32'd1);
      check("d1_lat_data", obs_data, 32'd1);
      cycle(0, 0, 1, 3, 1);
      cycle(0, 0, 1, 4, 1);
      cycle(0, 0, 1, 5, 1);
      check("d1_stream", obs_data, 32'd4);
      idle(2, 1);

      cycle(0, 0, 1, 32'hA, 0);
      cycle(0, 0, 1, 32'hB, 0);
      check("d1_bp_rdy", 32'(obs_rdy), 32'd0);
      check("d1_bp_data", obs_data, 32'hA);
      check("d1_bp_cnt", obs_cnt, 32'd1);
      cycle(0, 0, 1, 32'hB, 1);
      check("d1_pass_rdy", 32'(obs_rdy), 32'd1);
      cycle(0, 0, 0, 0, 1);
      check("d1_bp_out_b", obs_data, 32'hB);
      idle(2, 1);

      random_phase(400);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
